// File: rtl/fd_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} between IF and ID.
// Define FDQ_PC8_EN to add the d_pc8 (head pc + 8) link-value output.
module fd_inst_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          f_valid,
    input  logic [31:0]   f_pc,
    input  logic [31:0]   f_instr,
    output logic          f_ready,
    input  logic          d_ready,
    output logic          d_valid,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_instr,
`ifdef FDQ_PC8_EN
    output logic [31:0]   d_pc8,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [63:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic push;
    logic pop;
    logic [63:0] head;

    // Ready/valid come from registered occupancy only, so IF stalls solely on a full queue.
    assign f_ready = (count != FULL_COUNT);
    assign d_valid = (count != '0);
    assign push    = f_valid & f_ready;
    assign pop     = d_valid & d_ready;

    assign head    = mem[rd_ptr];
    assign d_pc    = d_valid ? head[63:32] : 32'd0;
    assign d_instr = d_valid ? head[31:0]  : 32'd0;

`ifdef FDQ_PC8_EN
    assign d_pc8   = d_valid ? (head[63:32] + 32'd8) : 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 64'd0;
            end
        end else if (flush) begin
            // Stale storage is left in place; zero count masks it from ID.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {f_pc, f_instr};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_inst_queue.sv
// Scoreboard bench for fd_inst_queue (DEPTH = 2); a queue model tracks expected contents.
module tb_fd_inst_queue;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          f_valid;
    logic [31:0]   f_pc;
    logic [31:0]   f_instr;
    logic          f_ready;
    logic          d_ready;
    logic          d_valid;
    logic [31:0]   d_pc;
    logic [31:0]   d_instr;
`ifdef FDQ_PC8_EN
    logic [31:0]   d_pc8;
`endif
    logic [AW:0]   count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fd_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_ready (f_ready),
        .d_ready (d_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
`ifdef FDQ_PC8_EN
        .d_pc8   (d_pc8),
`endif
        .count   (count)
    );

    // Advance one edge and update the scoreboard from the inputs driven this cycle.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        do_push = f_valid && (sb.size() < DEPTH);
        do_pop  = d_ready && (sb.size() != 0);
        @(posedge clk);
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({f_pc, f_instr});
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        f_pc = 32'd0; f_instr = 32'd0;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        n_checks++; if (f_ready !== 1'b1) $display("[TB] FAIL reset_f_ready: got %b expected 1", f_ready); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("[TB] FAIL reset_d_valid: got %b expected 0", d_valid); else n_pass++;
        n_checks++; if (d_pc !== 32'd0) $display("[TB] FAIL reset_d_pc: got %h expected 0", d_pc); else n_pass++;
        n_checks++; if (d_instr !== 32'd0) $display("[TB] FAIL reset_d_instr: got %h expected 0", d_instr); else n_pass++;
        n_checks++; if (count !== 2'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_fill();
        d_ready = 1'b0;
        f_valid = 1'b1; f_pc = 32'h3000; f_instr = 32'h24010001;
        cycle();
        n_checks++; if (d_pc !== 32'h3000) $display("[TB] FAIL fill_first_visible: got %h expected 3000", d_pc); else n_pass++;
        f_pc = 32'h3004; f_instr = 32'h24020002;
        cycle();
        n_checks++; if (count !== 2'd2) $display("[TB] FAIL fill_count: got %0d expected 2", count); else n_pass++;
        n_checks++; if (f_ready !== 1'b0) $display("[TB] FAIL fill_f_ready: got %b expected 0", f_ready); else n_pass++;
        n_checks++; if (d_pc !== 32'h3000 || d_instr !== 32'h24010001)
            $display("[TB] FAIL fill_head: got %h/%h expected 00003000/24010001", d_pc, d_instr); else n_pass++;
        f_pc = 32'h3008; f_instr = 32'h24030003;
        cycle();
        n_checks++; if (count !== 2'd2) $display("[TB] FAIL full_refuse_count: got %0d expected 2", count); else n_pass++;
        n_checks++; if ({d_pc, d_instr} !== sb[0] || d_pc !== 32'h3000)
            $display("[TB] FAIL full_refuse_head: got %h expected 3000", d_pc); else n_pass++;
    endtask

    task automatic test_drain_wrap();
        logic [31:0] pcs [2];
        logic [31:0] exp_order [4];
        int idx;
        int popped;
        pcs[0] = 32'h3008; pcs[1] = 32'h300C;
        exp_order[0] = 32'h3000; exp_order[1] = 32'h3004;
        exp_order[2] = 32'h3008; exp_order[3] = 32'h300C;
        idx = 0;
        popped = 0;
        d_ready = 1'b1;
        for (int c = 0; c < 10 && (idx < 2 || sb.size() != 0); c++) begin
            f_valid = (idx < 2);
            f_pc    = (idx < 2) ? pcs[idx] : 32'd0;
            f_instr = 32'h24000000 | f_pc;
            if (sb.size() != 0) begin
                n_checks++; if ({d_pc, d_instr} !== sb[0] || d_pc !== exp_order[popped])
                    $display("[TB] FAIL drain_order: got %h expected %h", d_pc, exp_order[popped]); else n_pass++;
                popped++;
            end
            if (f_valid && sb.size() < DEPTH) idx++;
            cycle();
            n_checks++; if (count !== 2'(sb.size()) || count > 2'd2)
                $display("[TB] FAIL drain_count: got %0d expected %0d", count, sb.size()); else n_pass++;
        end
        f_valid = 1'b0;
        n_checks++; if (popped != 4) $display("[TB] FAIL drain_total: got %0d expected 4", popped); else n_pass++;
        n_checks++; if (d_valid !== 1'b0) $display("[TB] FAIL drain_empty: got %b expected 0", d_valid); else n_pass++;
    endtask

    task automatic test_simultaneous();
        d_ready = 1'b1;
        f_valid = 1'b1; f_pc = 32'h5000; f_instr = 32'h11111111;
        #1;
        n_checks++; if (d_valid !== 1'b0) $display("[TB] FAIL no_bypass: got %b expected 0", d_valid); else n_pass++;
        cycle();
        n_checks++; if (count !== 2'd1) $display("[TB] FAIL empty_push_only: got %0d expected 1", count); else n_pass++;
        f_pc = 32'h5004; f_instr = 32'h22222222;
        cycle();
        n_checks++; if (count !== 2'd1) $display("[TB] FAIL simul_count: got %0d expected 1", count); else n_pass++;
        n_checks++; if ({d_pc, d_instr} !== sb[0] || d_pc !== 32'h5004)
            $display("[TB] FAIL simul_head: got %h expected 5004", d_pc); else n_pass++;
        f_valid = 1'b0;
        cycle();
        n_checks++; if (count !== 2'd0) $display("[TB] FAIL simul_drain: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_flush();
        d_ready = 1'b0;
        f_valid = 1'b1; f_pc = 32'h6000; f_instr = 32'h33333333;
        cycle();
        f_pc = 32'h6004; f_instr = 32'h44444444;
        cycle();
        n_checks++; if (count !== 2'd2) $display("[TB] FAIL preflush_count: got %0d expected 2", count); else n_pass++;
        flush = 1'b1; d_ready = 1'b1; f_pc = 32'h4000; f_instr = 32'h55555555;
        cycle();
        flush = 1'b0; d_ready = 1'b0;
        n_checks++; if (count !== 2'd0) $display("[TB] FAIL flush_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (d_valid !== 1'b0 || d_pc !== 32'd0 || d_instr !== 32'd0)
            $display("[TB] FAIL flush_outputs: got %b/%h/%h expected 0/0/0", d_valid, d_pc, d_instr); else n_pass++;
        cycle();
        f_valid = 1'b0;
        n_checks++; if (d_pc !== 32'h4000 || {d_pc, d_instr} !== sb[0])
            $display("[TB] FAIL post_flush_push: got %h expected 4000", d_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        f_valid = 1'b1; f_pc = 32'h7000; f_instr = 32'h66666666;
        cycle();
        f_valid = 1'b0; reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++; if (count !== 2'd0 || d_valid !== 1'b0 || f_ready !== 1'b1)
            $display("[TB] FAIL reset_mid: got count %0d valid %b ready %b expected 0/0/1", count, d_valid, f_ready); else n_pass++;
        n_checks++; if (d_pc !== 32'd0) $display("[TB] FAIL reset_mid_pc: got %h expected 0", d_pc); else n_pass++;
    endtask

`ifdef FDQ_PC8_EN
    task automatic test_pc8();
        d_ready = 1'b0;
        n_checks++; if (d_pc8 !== 32'd0) $display("[TB] FAIL pc8_empty_start: got %h expected 0", d_pc8); else n_pass++;
        f_valid = 1'b1; f_pc = 32'h00003010; f_instr = 32'h0;
        cycle();
        f_pc = 32'hFFFFFFFC;
        cycle();
        f_valid = 1'b0;
        n_checks++; if (d_pc8 !== 32'h00003018) $display("[TB] FAIL pc8_normal: got %h expected 00003018", d_pc8); else n_pass++;
        d_ready = 1'b1;
        cycle();
        n_checks++; if (d_pc8 !== 32'h00000004) $display("[TB] FAIL pc8_wrap: got %h expected 00000004", d_pc8); else n_pass++;
        cycle();
        d_ready = 1'b0;
        n_checks++; if (d_pc8 !== 32'd0) $display("[TB] FAIL pc8_empty: got %h expected 0", d_pc8); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_flush();
        test_reset_mid();
`ifdef FDQ_PC8_EN
        test_pc8();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fd_inst_queue.md
Name: fd_inst_queue

Overview:
- Fetch-to-decode instruction queue. Sits directly downstream of the IF stage and upstream of the ID stage.
- Captures {PC, Instr} pairs from IF in a small circular buffer and presents the oldest entry to ID with a valid/ready handshake.
- f_ready drives IF's en, so IF stalls only when the queue is full, not on every decode stall.
- flush discards all buffered fetches on redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- AW, 1, pointer width = log2(DEPTH); the instantiator keeps it consistent with DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries at next edge (branch/jump redirect).
- f_valid  input  1  IF presents a fetched instruction this cycle.
- f_pc  input  32  PC of fetched instruction.
- f_instr  input  32  fetched instruction word.
- f_ready  output  1  queue can accept; wired to IF en.
- d_ready  input  1  ID can consume (not stalled).
- d_valid  output  1  head entry valid.
- d_pc  output  32  PC of head entry.
- d_instr  output  32  instruction of head entry.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Storage:
  - DEPTH x 64-bit register array.
  - rd_ptr and wr_ptr, AW bits each, wrap modulo DEPTH.
  - count register, AW+1 bits.
- Reset:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - All storage entries cleared to 0.
  - Resulting outputs: f_ready = 1, d_valid = 0, d_pc = 0, d_instr = 0.
- Combinational status:
  - f_ready = (count != DEPTH). Depends only on state, never on d_ready. No combinational path from f_valid or d_ready to either ready/valid output.
  - d_valid = (count != 0).
  - d_pc / d_instr = head entry when d_valid = 1. Forced to 0 when empty, so ID sees a nop (sll $0,$0,0).
- Push = f_valid & f_ready. At the edge: write {f_pc, f_instr} at wr_ptr, then wr_ptr += 1.
- Pop = d_valid & d_ready. At the edge: rd_ptr += 1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an entry pushed at edge N is visible on d_* after edge N. Minimum one-cycle IF-to-ID latency. No bypass when empty.
- Priority: reset > flush > push/pop.
- Flush:
  - At the edge: rd_ptr = wr_ptr = 0, count = 0.
  - A simultaneous push or pop is ignored.
  - Storage contents are don't-care, but d_* must read 0 because count = 0.
- Boundary cases:
  - Full, pop and f_valid together: pop happens, push is refused (f_ready = 0). count becomes DEPTH-1 and f_ready rises the next cycle.
  - Empty with f_valid and d_ready: push only, no pop. count becomes 1.
  - Push and pop in the same cycle when 0 < count < DEPTH: count unchanged, both pointers advance.
  - Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. FIFO order is preserved across the wrap.
  - Reset mid-operation: all state returns to reset values in one cycle, whatever the contents.
- Overflow and underflow cannot occur. Pushing while full and popping while empty are both gated.

Optional Feature:
- Macro FDQ_PC8_EN.
- Defined:
  - Adds output port d_pc8 (32 bits) = d_pc + 32'd8, with 32-bit wrap-around. ID uses it as the jal/jalr link value.
  - d_pc8 = 0 when d_valid = 0.
  - Combinational from head storage; adds no latency.
- Not defined: port absent, no adder. All other behaviour is identical.

Test Plan:
- Reset then idle: assert reset for 2 cycles, f_valid = 0 -> f_ready = 1, d_valid = 0, d_pc = 0, d_instr = 0, count = 0.
- Fill to full with d_ready = 0, DEPTH = 2: push (0x3000, 0x24010001) then (0x3004, 0x24020002) -> count = 2, f_ready = 0. Head shows 0x3000 / 0x24010001. A third f_valid (0x3008) is not accepted.
- Drain order and wrap:
  - From full, set d_ready = 1 and keep pushing 0x3008, 0x300C.
  - Required: d_pc sequence is 0x3000, 0x3004, 0x3008, 0x300C, each held for exactly one cycle once streaming. count never exceeds 2. Pointers wrap correctly.
- Simultaneous push/pop at count = 1 -> count stays 1, head advances to the newly pushed PC one cycle later.
- Flush priority: count = 2, assert flush together with f_valid (0x4000) and d_ready = 1 -> next cycle count = 0, d_valid = 0, 0x4000 not stored. The following push of 0x4000 appears on d_pc one cycle after acceptance.
- FDQ_PC8_EN build: head d_pc = 0x00003010 -> d_pc8 = 0x00003018. Head d_pc = 0xFFFFFFFC -> d_pc8 = 0x00000004. Empty -> d_pc8 = 0.
